// File: rtl/seven_seg_pkg.sv
// Shared types and hex-to-segment patterns for the multiplexed seven-segment driver.
// Patterns are active-high in {g,f,e,d,c,b,a} order.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF   = 7'b0000000;
  localparam seg_t SEG_HEX_0 = 7'b0111111;
  localparam seg_t SEG_HEX_1 = 7'b0000110;
  localparam seg_t SEG_HEX_2 = 7'b1011011;
  localparam seg_t SEG_HEX_3 = 7'b1001111;
  localparam seg_t SEG_HEX_4 = 7'b1100110;
  localparam seg_t SEG_HEX_5 = 7'b1101101;
  localparam seg_t SEG_HEX_6 = 7'b1111101;
  localparam seg_t SEG_HEX_7 = 7'b0000111;
  localparam seg_t SEG_HEX_8 = 7'b1111111;
  localparam seg_t SEG_HEX_9 = 7'b1101111;
  localparam seg_t SEG_HEX_A = 7'b1110111;
  localparam seg_t SEG_HEX_B = 7'b1111100;
  localparam seg_t SEG_HEX_C = 7'b0111001;
  localparam seg_t SEG_HEX_D = 7'b1011110;
  localparam seg_t SEG_HEX_E = 7'b1111001;
  localparam seg_t SEG_HEX_F = 7'b1110001;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    s = SEG_OFF;
    case (nib)
      4'h0: s = SEG_HEX_0;
      4'h1: s = SEG_HEX_1;
      4'h2: s = SEG_HEX_2;
      4'h3: s = SEG_HEX_3;
      4'h4: s = SEG_HEX_4;
      4'h5: s = SEG_HEX_5;
      4'h6: s = SEG_HEX_6;
      4'h7: s = SEG_HEX_7;
      4'h8: s = SEG_HEX_8;
      4'h9: s = SEG_HEX_9;
      4'hA: s = SEG_HEX_A;
      4'hB: s = SEG_HEX_B;
      4'hC: s = SEG_HEX_C;
      4'hD: s = SEG_HEX_D;
      4'hE: s = SEG_HEX_E;
      4'hF: s = SEG_HEX_F;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_segment.sv
// Combinational hex nibble to active-high seven-segment decoder.
module seven_segment
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output seg_t       o_seg_c
);

  assign o_seg_c = hex_to_seg(i_hex);

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit seven-segment scanner with double-buffered digits,
// per-slot dead-time, blank mask and leading-zero suppression.
module seven_segment_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int unsigned DW    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t                  SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DW-1:0]         r_pend_digits;
  logic [DW-1:0]         r_act_digits;
  logic [NUM_DIGITS-1:0] r_pend_blank;
  logic [NUM_DIGITS-1:0] r_act_blank;
  logic                  r_pending;
  seg_t                  r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_start;

  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_slot_end;
  logic                  w_commit;
  logic                  w_upper_zero;
  logic [NUM_DIGITS-1:0] w_lit;
  logic [3:0]            w_nib;
  logic                  w_cur_lit;
  logic                  w_live;
  logic [NUM_DIGITS-1:0] w_an_hot;
  seg_t                  w_seg_hi;

  // Slot counter and digit index; commit point is the wrap into (0,0)
  always_comb begin
    w_slot_end = (r_cnt == CNT_MAX);
    w_commit   = w_slot_end && (r_idx == IDX_MAX);
    w_cnt_nxt  = r_cnt + CNT_W'(1);
    w_idx_nxt  = r_idx;
    if (w_slot_end) begin
      w_cnt_nxt = '0;
      w_idx_nxt = w_commit ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // Double buffer: a load on the commit edge lands in pend after the old pend moves to act
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_digits <= '0;
      r_pend_blank  <= '1;
      r_act_digits  <= '0;
      r_act_blank   <= '1;
      r_pending     <= 1'b0;
    end else begin
      if (w_commit && r_pending) begin
        r_act_digits <= r_pend_digits;
        r_act_blank  <= r_pend_blank;
      end
      if (load) begin
        r_pend_digits <= digits_in;
        r_pend_blank  <= blank_in;
      end
      if (load) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Visibility per digit: MSB-down zero run drives leading-zero suppression
  always_comb begin
    w_upper_zero = 1'b1;
    w_lit        = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_upper_zero = w_upper_zero && (r_act_digits[4*k +: 4] == 4'h0);
      w_lit[k]     = !r_act_blank[k] && !(lz_en && (k != 0) && w_upper_zero);
    end
  end

  always_comb begin
    w_nib     = 4'h0;
    w_cur_lit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib     = r_act_digits[4*k +: 4];
        w_cur_lit = w_lit[k];
      end
    end
  end

  seven_segment u_dec (
    .i_hex   (w_nib),
    .o_seg_c (w_seg_hi)
  );

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign w_live = 1'b1;
    end else begin : g_dead
      assign w_live = (r_cnt >= CNT_W'(DEAD_CYCLES));
    end
  endgenerate

  assign w_an_hot = NUM_DIGITS'(1) << r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg         <= SEG_OFF ^ SEG_POL;
      r_an          <= AN_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= (w_cur_lit ? w_seg_hi : SEG_OFF) ^ SEG_POL;
      r_an          <= ((w_cur_lit && w_live) ? w_an_hot : '0) ^ AN_POL;
      r_frame_start <= (r_idx == '0) && (r_cnt == '0);
    end
  end

  assign seg         = r_seg;
  assign an          = r_an;
  assign frame_start = r_frame_start;
  assign pending     = r_pending;

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised, time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. It holds a double-buffered set of hex digits and scans one digit at a time, with dead-time between digits to suppress ghosting, a per-digit blank mask and optional leading-zero suppression. It sits between the slot-machine game logic, which issues `load` pulses, and the board's segment/anode pins. A single shared segment decoder serves all digits.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits, 1..8; digit NUM_DIGITS-1 is the most significant.
- REFRESH_DIV, 1000: clocks per digit slot; must be ≥ DEAD_CYCLES+1.
- DEAD_CYCLES, 2: clocks at the start of each slot with all anodes off; may be 0.
- SEG_ACTIVE_LOW, 1: 1 drives segments low when lit.
- AN_ACTIVE_LOW, 1: 1 drives the anode enable low when on.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  async active-high reset
- load  in  1  single-cycle strobe that captures digits_in/blank_in into the pending buffer
- digits_in  in  4*NUM_DIGITS  hex nibbles; [4k+3:4k] is digit k
- blank_in  in  NUM_DIGITS  1 = force digit k dark
- lz_en  in  1  leading-zero suppression enable; sampled live, not buffered
- seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- an  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW
- frame_start  out  1  one-cycle pulse at the start of the digit-0 slot
- pending  out  1  loaded data not yet committed to the display

## Operation
- State is a slot counter `cnt` (0..REFRESH_DIV-1, width $clog2(REFRESH_DIV), minimum 1) and a digit index `idx` (0..NUM_DIGITS-1).
- `cnt` increments every clock. At REFRESH_DIV-1 it wraps to 0 and `idx` advances; `idx` wraps NUM_DIGITS-1 → 0.
- Buffers: `pend_*` and `act_*` (digits and blank). On `load`, `pend` is written and `pending` is set. A second load before commit overwrites `pend`; the latest load wins.
- Commit happens on the edge where the state wraps into (idx=0, cnt=0). If `pending`=1, then `act` ← `pend` and `pending` clears.
- If `load` arrives on the commit edge, the previous `pend` commits, the new data becomes `pend`, and `pending` stays 1.
- Digit k is lit only if all of the following hold:
  - blank bit k is 0.
  - It is not a suppressed leading zero. With lz_en=1, digit k (k>0) is suppressed when it and every more significant digit equal 0. Digit 0 is never suppressed.
- The anode is on only when cnt ≥ DEAD_CYCLES. When the slot's digit is dark, `an` stays off for the whole slot.
- Segment patterns are the standard hex 0–F, active-high internally, then inverted if SEG_ACTIVE_LOW. Examples: 0 = 7'b0111111, 1 = 7'b0000110, F = 7'b1110001. Off = 7'b0000000.
- frame_start is 1 for the cycle corresponding to state (0,0).

## Timing
- seg, an and frame_start are registered. In cycle n they reflect (idx,cnt) and `act` from cycle n-1, giving a fixed 1-clock latency.
- Reset, at assertion and held:
  - cnt=0, idx=0, `act`/`pend` digits 0 and blank all 1, `pending`=0.
  - an all off, seg off pattern, frame_start 0.
- The display is dark until the first commit.
- Reset mid-frame clears everything immediately and asynchronously. Pending data is lost.
- Load-to-visible latency is at most NUM_DIGITS*REFRESH_DIV + 1 clocks.
- Full frame period is NUM_DIGITS*REFRESH_DIV clocks.
- At most one anode is on in any cycle, and none during dead-time.

## Structure
- Package `seven_seg_pkg`:
  - typedef `seg_t` (logic [6:0]).
  - Localparams SEG_OFF and the 16 hex pattern constants.
  - Function `hex_to_seg`.
- One sub-module: reuse the existing `seven_segment` decoder (4-bit in, 7-bit active-high out). Instantiate it once on the muxed `act` nibble; polarity inversion happens in this block.
- Leading-zero logic is a combinational scan over `act` digits, MSB down.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, both polarities active-low.
- Reset, no load → an=4'b1111 and seg=7'b1111111 for 3 full frames; frame_start pulses every 16 clocks.
- load digits_in=16'h1234, blank_in=0 → pending=1 until the next wrap.
  - From the next frame: slot 0 shows seg=~4 (7'b0011001) with an=4'b1110 on cnt 1..3, and an=4'b1111 on cnt 0.
  - Slot 3 shows ~1 (7'b1111001) with an=4'b0111.
- load 16'h0070 with lz_en=1 → digits 3 and 2 stay dark for the whole slot; digit 1 shows 7; digit 0 shows 0. With lz_en=0, digits 3 and 2 show 0.
- Back-to-back loads 16'hAAAA, then 16'h5555 within one frame → only 5555 is ever displayed.
- Load on the exact commit edge → the old pend displays; the new data displays one frame later; pending stays 1 across that edge.
- Assert reset at mid-slot idx=2, cnt=2 → the same cycle shows an all off, pending=0, and the display is dark afterwards until a new load commits.
